// File: rtl/grp_axi_split_pkg.sv
// Shared types and helpers for grp_axi_split: B-join states, response merge, group AXI size.
// Default channel structs describe a 512-bit system bus split into 4 x 128-bit groups.
package grp_axi_split_pkg;

    localparam int unsigned AddrWidth    = 32;
    localparam int unsigned IdWidth      = 4;
    localparam int unsigned UserWidth    = 1;
    localparam int unsigned SysDataWidth = 512;
    localparam int unsigned GrpDataWidth = 128;
    localparam int unsigned MaxGroups    = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {B_COLLECT, B_PRESENT} b_state_e;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [IdWidth-1:0]   id;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [3:0]           cache;
        logic [UserWidth-1:0] user;
    } ax_t;

    typedef struct packed {
        logic [SysDataWidth-1:0]   data;
        logic [SysDataWidth/8-1:0] strb;
        logic                      last;
        logic [UserWidth-1:0]      user;
    } sys_w_t;

    typedef struct packed {
        logic [GrpDataWidth-1:0]   data;
        logic [GrpDataWidth/8-1:0] strb;
        logic                      last;
        logic [UserWidth-1:0]      user;
    } grp_w_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_t;

    typedef struct packed {
        logic [IdWidth-1:0]      id;
        logic [SysDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
        logic [UserWidth-1:0]    user;
    } sys_r_t;

    typedef struct packed {
        logic [IdWidth-1:0]      id;
        logic [GrpDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
        logic [UserWidth-1:0]    user;
    } grp_r_t;

    typedef struct packed {
        ax_t    aw;
        logic   aw_valid;
        sys_w_t w;
        logic   w_valid;
        logic   b_ready;
        ax_t    ar;
        logic   ar_valid;
        logic   r_ready;
    } sys_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        b_t     b;
        logic   r_valid;
        sys_r_t r;
    } sys_resp_t;

    typedef struct packed {
        ax_t    aw;
        logic   aw_valid;
        grp_w_t w;
        logic   w_valid;
        logic   b_ready;
        ax_t    ar;
        logic   ar_valid;
        logic   r_ready;
    } grp_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        b_t     b;
        logic   r_valid;
        grp_r_t r;
    } grp_resp_t;

    function automatic int unsigned grp_size(input int unsigned width);
        return $clog2(width) - 3;
    endfunction

    // Errors win with the worst code; EXOKAY survives only if every group reports it.
    function automatic logic [1:0] merge_resp(input logic [MaxGroups-1:0][1:0] resp,
                                              input int unsigned n);
        logic       err;
        logic       all_ex;
        logic [1:0] worst;
        err    = 1'b0;
        all_ex = 1'b1;
        worst  = RESP_OKAY;
        for (int unsigned i = 0; i < MaxGroups; i++) begin
            if (i < n) begin
                if (resp[i][1])            err    = 1'b1;
                if (resp[i] > worst)       worst  = resp[i];
                if (resp[i] != RESP_EXOKAY) all_ex = 1'b0;
            end
        end
        if (err)         return worst;
        else if (all_ex) return RESP_EXOKAY;
        else             return RESP_OKAY;
    endfunction

endpackage

// File: rtl/grp_axi_split_grp_r_fifo.sv
// Two-entry FIFO buffering one group's R beats so groups may run up to two beats apart.
// Output is registered: a pushed beat becomes visible the cycle after the push.
module grp_r_fifo #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data
);

    logic [1:0][Width-1:0] mem_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  push;
    logic                  pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: storage is deliberately left out of reset; count_q guards every read of it.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: rtl/grp_axi_split.sv
// Forks one wide AXI port into NrGroups narrow group ports and joins R/B back together.
// Define GRP_AXI_SPLIT_RSKEW_EN to buffer each group's R path in a 2-entry grp_r_fifo.
module grp_axi_split
    import grp_axi_split_pkg::*;
#(
    parameter int unsigned NrGroups        = 4,
    parameter int unsigned AxiDataWidth    = 512,
    parameter int unsigned GrpAxiDataWidth = 128,
    parameter type         axi_req_t       = sys_req_t,
    parameter type         axi_resp_t      = sys_resp_t,
    parameter type         grp_axi_req_t   = grp_req_t,
    parameter type         grp_axi_resp_t  = grp_resp_t,
    parameter type         grp_r_chan_t    = grp_r_t
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  axi_req_t                     axi_req_i,
    output axi_resp_t                    axi_resp_o,
    output grp_axi_req_t  [NrGroups-1:0] grp_axi_req_o,
    input  grp_axi_resp_t [NrGroups-1:0] grp_axi_resp_i
);

    localparam int unsigned GrpStrbWidth = GrpAxiDataWidth / 8;
    localparam logic [2:0]  GrpSize      = 3'(grp_size(GrpAxiDataWidth));

    logic [NrGroups-1:0] aw_acc_q, ar_acc_q, w_acc_q;
    logic [NrGroups-1:0] aw_grp_ready, ar_grp_ready, w_grp_ready;
    logic [NrGroups-1:0] aw_grp_valid, ar_grp_valid, w_grp_valid;
    logic                aw_ready, ar_ready, w_ready;

    // ---------------- AW / AR / W fork ----------------
    always_comb begin
        for (int g = 0; g < NrGroups; g++) begin
            aw_grp_ready[g] = grp_axi_resp_i[g].aw_ready;
            ar_grp_ready[g] = grp_axi_resp_i[g].ar_ready;
            w_grp_ready[g]  = grp_axi_resp_i[g].w_ready;
        end
    end

    assign aw_grp_valid = {NrGroups{axi_req_i.aw_valid}} & ~aw_acc_q;
    assign ar_grp_valid = {NrGroups{axi_req_i.ar_valid}} & ~ar_acc_q;
    assign w_grp_valid  = {NrGroups{axi_req_i.w_valid}}  & ~w_acc_q;
    assign aw_ready     = &(aw_acc_q | aw_grp_ready);
    assign ar_ready     = &(ar_acc_q | ar_grp_ready);
    assign w_ready      = &(w_acc_q  | w_grp_ready);

    // NOTE: non-blocking assignments only in clocked blocks; the clear branch comes first
    // so a group handshake coinciding with the system handshake leaves no stale bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_acc_q <= '0;
            ar_acc_q <= '0;
            w_acc_q  <= '0;
        end else begin
            aw_acc_q <= (axi_req_i.aw_valid && aw_ready) ? '0 : (aw_acc_q | (aw_grp_valid & aw_grp_ready));
            ar_acc_q <= (axi_req_i.ar_valid && ar_ready) ? '0 : (ar_acc_q | (ar_grp_valid & ar_grp_ready));
            w_acc_q  <= (axi_req_i.w_valid  && w_ready)  ? '0 : (w_acc_q  | (w_grp_valid  & w_grp_ready));
        end
    end

    // ---------------- B join ----------------
    b_state_e                  b_state_q;
    logic [NrGroups-1:0]       got_q;
    logic [NrGroups-1:0][1:0]  b_resp_q;
    logic [IdWidth-1:0]        b_id_q;
    logic                      b_valid_q;
    logic [NrGroups-1:0]       b_ready_vec;
    logic [NrGroups-1:0]       b_hs;

    assign b_ready_vec = (b_state_q == B_COLLECT) ? ~got_q : '0;

    always_comb begin
        for (int g = 0; g < NrGroups; g++) b_hs[g] = grp_axi_resp_i[g].b_valid & b_ready_vec[g];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            b_state_q <= B_COLLECT;
            got_q     <= '0;
            b_resp_q  <= '0;
            b_id_q    <= '0;
            b_valid_q <= 1'b0;
        end else begin
            case (b_state_q)
                B_COLLECT: begin
                    for (int g = 0; g < NrGroups; g++) begin
                        if (b_hs[g]) b_resp_q[g] <= grp_axi_resp_i[g].b.resp;
                    end
                    if (b_hs[0]) b_id_q <= grp_axi_resp_i[0].b.id;
                    got_q <= got_q | b_hs;
                    if (&(got_q | b_hs)) begin
                        b_state_q <= B_PRESENT;
                        b_valid_q <= 1'b1;
                    end
                end
                B_PRESENT: begin
                    if (axi_req_i.b_ready) begin
                        got_q     <= '0;
                        b_state_q <= B_COLLECT;
                        b_valid_q <= 1'b0;
                    end
                end
                default: b_state_q <= B_COLLECT;
            endcase
        end
    end

    // ---------------- R join ----------------
    logic        [NrGroups-1:0] r_head_valid;
    grp_r_chan_t [NrGroups-1:0] r_head;
    logic        [NrGroups-1:0] r_ready_vec;
    logic                       r_valid;
    logic                       r_pop;

    assign r_valid = &r_head_valid;
    assign r_pop   = r_valid & axi_req_i.r_ready;

`ifdef GRP_AXI_SPLIT_RSKEW_EN
    for (genvar g = 0; g < NrGroups; g++) begin : g_r_fifo
        grp_r_fifo #(
            .Width($bits(grp_r_chan_t))
        ) i_grp_r_fifo (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .in_valid (grp_axi_resp_i[g].r_valid),
            .in_ready (r_ready_vec[g]),
            .in_data  (grp_axi_resp_i[g].r),
            .out_valid(r_head_valid[g]),
            .out_ready(r_pop),
            .out_data (r_head[g])
        );
    end
`else
    always_comb begin
        for (int g = 0; g < NrGroups; g++) begin
            r_head_valid[g] = grp_axi_resp_i[g].r_valid;
            r_head[g]       = grp_axi_resp_i[g].r;
        end
        r_ready_vec = {NrGroups{r_pop}};
    end
`endif

    logic [AxiDataWidth-1:0]        r_data;
    logic [MaxGroups-1:0][1:0]      r_resp_pad;
    logic [MaxGroups-1:0][1:0]      b_resp_pad;
    logic                           unused_bits;

    always_comb begin
        r_resp_pad  = '0;
        b_resp_pad  = '0;
        r_data      = '0;
        unused_bits = 1'b0;
        for (int g = 0; g < NrGroups; g++) begin
            r_data[g*GrpAxiDataWidth +: GrpAxiDataWidth] = r_head[g].data;
            r_resp_pad[g] = r_head[g].resp;
            b_resp_pad[g] = b_resp_q[g];
            unused_bits   = unused_bits ^ (^{grp_axi_resp_i[g].b.id, grp_axi_resp_i[g].b.user,
                                             r_head[g].id, r_head[g].last, r_head[g].user});
        end
    end

    // ---------------- Output assembly ----------------
    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    always_comb begin
        for (int g = 0; g < NrGroups; g++) begin
            grp_axi_req_o[g]          = '0;
            grp_axi_req_o[g].aw.addr  = axi_req_i.aw.addr;
            grp_axi_req_o[g].aw.id    = axi_req_i.aw.id;
            grp_axi_req_o[g].aw.len   = axi_req_i.aw.len;
            grp_axi_req_o[g].aw.size  = (axi_req_i.aw.size > GrpSize) ? GrpSize : axi_req_i.aw.size;
            grp_axi_req_o[g].aw.burst = axi_req_i.aw.burst;
            grp_axi_req_o[g].aw.cache = axi_req_i.aw.cache;
            grp_axi_req_o[g].aw.user  = axi_req_i.aw.user;
            grp_axi_req_o[g].aw_valid = aw_grp_valid[g];
            grp_axi_req_o[g].ar.addr  = axi_req_i.ar.addr;
            grp_axi_req_o[g].ar.id    = axi_req_i.ar.id;
            grp_axi_req_o[g].ar.len   = axi_req_i.ar.len;
            grp_axi_req_o[g].ar.size  = (axi_req_i.ar.size > GrpSize) ? GrpSize : axi_req_i.ar.size;
            grp_axi_req_o[g].ar.burst = axi_req_i.ar.burst;
            grp_axi_req_o[g].ar.cache = axi_req_i.ar.cache;
            grp_axi_req_o[g].ar.user  = axi_req_i.ar.user;
            grp_axi_req_o[g].ar_valid = ar_grp_valid[g];
            grp_axi_req_o[g].w.data   = axi_req_i.w.data[g*GrpAxiDataWidth +: GrpAxiDataWidth];
            grp_axi_req_o[g].w.strb   = axi_req_i.w.strb[g*GrpStrbWidth +: GrpStrbWidth];
            grp_axi_req_o[g].w.last   = axi_req_i.w.last;
            grp_axi_req_o[g].w.user   = axi_req_i.w.user;
            grp_axi_req_o[g].w_valid  = w_grp_valid[g];
            grp_axi_req_o[g].b_ready  = b_ready_vec[g];
            grp_axi_req_o[g].r_ready  = r_ready_vec[g];
        end
    end

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready;
        axi_resp_o.ar_ready = ar_ready;
        axi_resp_o.w_ready  = w_ready;
        axi_resp_o.b_valid  = b_valid_q;
        axi_resp_o.b.id     = b_id_q;
        axi_resp_o.b.resp   = merge_resp(b_resp_pad, NrGroups);
        axi_resp_o.r_valid  = r_valid;
        axi_resp_o.r.data   = r_data;
        axi_resp_o.r.id     = r_head[0].id;
        axi_resp_o.r.last   = r_head[0].last;
        axi_resp_o.r.user   = r_head[0].user;
        axi_resp_o.r.resp   = merge_resp(r_resp_pad, NrGroups);
    end

endmodule

// File: tb/tb_grp_axi_split.sv
// Directed bench for grp_axi_split: address/data fork, R/B join, response merge, reset.
// The RSKEW scenario runs only when GRP_AXI_SPLIT_RSKEW_EN is defined.
module tb_grp_axi_split;
    import grp_axi_split_pkg::*;

    logic            clk = 1'b0;
    logic            rst_i;
    sys_req_t        axi_req;
    sys_resp_t       axi_resp;
    grp_req_t  [3:0] grp_req;
    grp_resp_t [3:0] grp_resp;

    int errors = 0;
    int checks = 0;

    logic [3:0] grp_aw_valid, grp_ar_valid, grp_w_valid, grp_b_ready, grp_r_ready;

    grp_axi_split #(
        .NrGroups       (4),
        .AxiDataWidth   (512),
        .GrpAxiDataWidth(128)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .axi_req_i     (axi_req),
        .axi_resp_o    (axi_resp),
        .grp_axi_req_o (grp_req),
        .grp_axi_resp_i(grp_resp)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int g = 0; g < 4; g++) begin
            grp_aw_valid[g] = grp_req[g].aw_valid;
            grp_ar_valid[g] = grp_req[g].ar_valid;
            grp_w_valid[g]  = grp_req[g].w_valid;
            grp_b_ready[g]  = grp_req[g].b_ready;
            grp_r_ready[g]  = grp_req[g].r_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i    = 1'b1;
        axi_req  = '0;
        grp_resp = '0;
        step();
        step();
        rst_i = 1'b0;
        @(negedge clk);
        checks++; if (axi_resp.b_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b want 0", axi_resp.b_valid); end
        checks++; if (axi_resp.b.resp !== 2'b00 || axi_resp.b.id !== 4'h0) begin errors++; $display("FAIL reset_b_fields: got resp %h id %h want 0 0", axi_resp.b.resp, axi_resp.b.id); end
        checks++; if (grp_b_ready !== 4'b1111) begin errors++; $display("FAIL reset_grp_b_ready: got %b want 1111", grp_b_ready); end
        checks++; if (grp_aw_valid !== 4'b0000) begin errors++; $display("FAIL reset_grp_aw_valid: got %b want 0000", grp_aw_valid); end
        checks++; if (axi_resp.r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid: got %b want 0", axi_resp.r_valid); end
    endtask

    task automatic set_ar_ready(input logic [3:0] v);
        for (int g = 0; g < 4; g++) grp_resp[g].ar_ready = v[g];
    endtask

    task automatic test_ar_fork();
        step();
        axi_req.ar_valid   = 1'b1;
        axi_req.ar.addr    = 32'h0000_1000;
        axi_req.ar.len     = 8'd7;
        axi_req.ar.size    = 3'd6;
        axi_req.ar.id      = 4'd3;
        axi_req.ar.burst   = 2'b01;
        set_ar_ready(4'b1010);
        @(negedge clk);
        checks++; if (grp_ar_valid !== 4'b1111) begin errors++; $display("FAIL ar_c0_grp_valid: got %b want 1111", grp_ar_valid); end
        checks++; if (axi_resp.ar_ready !== 1'b0) begin errors++; $display("FAIL ar_c0_ready: got %b want 0", axi_resp.ar_ready); end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (grp_req[g].ar.len !== 8'd7 || grp_req[g].ar.size !== 3'd4 || grp_req[g].ar.addr !== 32'h1000 ||
                grp_req[g].ar.id !== 4'd3 || grp_req[g].ar.burst !== 2'b01)
            begin
                errors++;
                $display("FAIL ar_fields_g%0d: got len %0d size %0d addr %h id %0d burst %0d want 7 4 1000 3 1",
                         g, grp_req[g].ar.len, grp_req[g].ar.size, grp_req[g].ar.addr, grp_req[g].ar.id, grp_req[g].ar.burst);
            end
        end
        step();
        set_ar_ready(4'b0101);
        @(negedge clk);
        checks++; if (grp_ar_valid !== 4'b0101) begin errors++; $display("FAIL ar_c1_grp_valid: got %b want 0101", grp_ar_valid); end
        checks++; if (axi_resp.ar_ready !== 1'b1) begin errors++; $display("FAIL ar_c1_ready: got %b want 1", axi_resp.ar_ready); end
        step();
        set_ar_ready(4'b0000);
        @(negedge clk);
        checks++; if (grp_ar_valid !== 4'b1111) begin errors++; $display("FAIL ar_c2_acc_clear: got %b want 1111", grp_ar_valid); end
        checks++; if (axi_resp.ar_ready !== 1'b0) begin errors++; $display("FAIL ar_c2_ready: got %b want 0", axi_resp.ar_ready); end
        axi_req.ar_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        step();
        for (int g = 0; g < 4; g++) grp_resp[g].aw_ready = 1'b1;
        axi_req.aw_valid = 1'b1;
        axi_req.aw.addr  = 32'h40;
        axi_req.aw.size  = 3'd2;
        @(negedge clk);
        checks++; if (axi_resp.aw_ready !== 1'b1 || grp_aw_valid !== 4'b1111) begin errors++; $display("FAIL b2b_first: got ready %b grp %b want 1 1111", axi_resp.aw_ready, grp_aw_valid); end
        checks++; if (grp_req[1].aw.size !== 3'd2) begin errors++; $display("FAIL b2b_small_size: got %0d want 2", grp_req[1].aw.size); end
        step();
        axi_req.aw.addr = 32'h80;
        axi_req.aw.size = 3'd4;
        @(negedge clk);
        checks++; if (axi_resp.aw_ready !== 1'b1 || grp_aw_valid !== 4'b1111) begin errors++; $display("FAIL b2b_second: got ready %b grp %b want 1 1111", axi_resp.aw_ready, grp_aw_valid); end
        checks++; if (grp_req[3].aw.size !== 3'd4 || grp_req[3].aw.addr !== 32'h80) begin errors++; $display("FAIL b2b_second_fields: got size %0d addr %h want 4 80", grp_req[3].aw.size, grp_req[3].aw.addr); end
        step();
        axi_req.aw_valid = 1'b0;
        @(negedge clk);
        checks++; if (grp_aw_valid !== 4'b0000) begin errors++; $display("FAIL b2b_idle: got %b want 0000", grp_aw_valid); end
    endtask

    task automatic test_w_split();
        logic [15:0]  exp_strb [4];
        logic [127:0] exp_data;
        exp_strb[0] = 16'hFFFF;
        exp_strb[1] = 16'h0000;
        exp_strb[2] = 16'hFFFF;
        exp_strb[3] = 16'h0000;
        step();
        for (int k = 0; k < 64; k++) axi_req.w.data[8*k +: 8] = 8'(k);
        axi_req.w.strb  = 64'h0000_FFFF_0000_FFFF;
        axi_req.w.last  = 1'b1;
        axi_req.w_valid = 1'b1;
        for (int g = 0; g < 4; g++) grp_resp[g].w_ready = 1'b1;
        @(negedge clk);
        checks++; if (grp_w_valid !== 4'b1111 || axi_resp.w_ready !== 1'b1) begin errors++; $display("FAIL w_valid: got grp %b ready %b want 1111 1", grp_w_valid, axi_resp.w_ready); end
        for (int g = 0; g < 4; g++) begin
            for (int j = 0; j < 16; j++) exp_data[8*j +: 8] = 8'(16*g + j);
            checks++;
            if (grp_req[g].w.data !== exp_data || grp_req[g].w.strb !== exp_strb[g] || grp_req[g].w.last !== 1'b1) begin
                errors++;
                $display("FAIL w_slice_g%0d: got data %h strb %h last %b want %h %h 1",
                         g, grp_req[g].w.data, grp_req[g].w.strb, grp_req[g].w.last, exp_data, exp_strb[g]);
            end
        end
        step();
        axi_req.w_valid = 1'b0;
        @(negedge clk);
        checks++; if (grp_w_valid !== 4'b0000) begin errors++; $display("FAIL w_single_beat: got %b want 0000", grp_w_valid); end
    endtask

    task automatic set_r(input logic [3:0] valid, input logic [7:0] resps);
        for (int g = 0; g < 4; g++) begin
            grp_resp[g].r_valid = valid[g];
            grp_resp[g].r.resp  = resps[2*g +: 2];
        end
    endtask

`ifndef GRP_AXI_SPLIT_RSKEW_EN
    task automatic test_r_skew();
        step();
        for (int g = 0; g < 4; g++) begin
            grp_resp[g].r.data = {32{4'(g + 1)}};
            grp_resp[g].r.id   = (g == 0) ? 4'd5 : 4'd9;
            grp_resp[g].r.last = (g == 0);
        end
        axi_req.r_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_r((c == 3) ? 4'b1111 : 4'b0111, 8'h00);
            @(negedge clk);
            if (c < 3) begin
                checks++; if (axi_resp.r_valid !== 1'b0 || grp_r_ready !== 4'b0000) begin errors++; $display("FAIL r_wait_c%0d: got valid %b grp_ready %b want 0 0000", c, axi_resp.r_valid, grp_r_ready); end
            end else begin
                checks++; if (axi_resp.r_valid !== 1'b1 || grp_r_ready !== 4'b1111) begin errors++; $display("FAIL r_join: got valid %b grp_ready %b want 1 1111", axi_resp.r_valid, grp_r_ready); end
                checks++; if (axi_resp.r.data !== {{32{4'h4}}, {32{4'h3}}, {32{4'h2}}, {32{4'h1}}}) begin errors++; $display("FAIL r_data_order: got %h", axi_resp.r.data); end
                checks++; if (axi_resp.r.id !== 4'd5 || axi_resp.r.last !== 1'b1) begin errors++; $display("FAIL r_id_last: got id %0d last %b want 5 1", axi_resp.r.id, axi_resp.r.last); end
            end
            if (c < 3) step();
        end
        step();
        set_r(4'b0000, 8'h00);
    endtask

    task automatic test_resp_merge();
        step();
        axi_req.r_ready = 1'b1;
        set_r(4'b1111, {RESP_OKAY, RESP_OKAY, RESP_EXOKAY, RESP_OKAY});
        @(negedge clk);
        checks++; if (axi_resp.r.resp !== RESP_OKAY) begin errors++; $display("FAIL merge_mixed_ex: got %0d want 0", axi_resp.r.resp); end
        step();
        set_r(4'b1111, {RESP_OKAY, RESP_DECERR, RESP_SLVERR, RESP_OKAY});
        @(negedge clk);
        checks++; if (axi_resp.r.resp !== RESP_DECERR) begin errors++; $display("FAIL merge_err: got %0d want 3", axi_resp.r.resp); end
        step();
        set_r(4'b1111, {4{RESP_EXOKAY}});
        @(negedge clk);
        checks++; if (axi_resp.r.resp !== RESP_EXOKAY) begin errors++; $display("FAIL merge_all_ex: got %0d want 1", axi_resp.r.resp); end
        step();
        set_r(4'b0000, 8'h00);
    endtask
`else
    task automatic test_rskew();
        step();
        axi_req.r_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            for (int g = 0; g < 4; g++) grp_resp[g].r_valid = 1'b0;
            if (c <= 2) begin
                grp_resp[0].r_valid = 1'b1;
                grp_resp[0].r.data  = {32{4'(c + 1)}};
            end
            if (c == 3 || c == 4) begin
                for (int g = 1; g < 4; g++) begin
                    grp_resp[g].r_valid = 1'b1;
                    grp_resp[g].r.data  = {32{4'(c + 5)}};
                end
            end
            @(negedge clk);
            if (c == 2) begin
                checks++; if (grp_r_ready[0] !== 1'b0) begin errors++; $display("FAIL rskew_g0_full: got %b want 0", grp_r_ready[0]); end
            end
            if (c < 4 || c == 6) begin
                checks++; if (axi_resp.r_valid !== 1'b0) begin errors++; $display("FAIL rskew_idle_c%0d: got %b want 0", c, axi_resp.r_valid); end
            end
            if (c == 4) begin
                checks++; if (axi_resp.r_valid !== 1'b1 || axi_resp.r.data !== {{96{4'h8}}, {32{4'h1}}}) begin errors++; $display("FAIL rskew_beat0: got valid %b data %h", axi_resp.r_valid, axi_resp.r.data); end
            end
            if (c == 5) begin
                checks++; if (axi_resp.r_valid !== 1'b1 || axi_resp.r.data !== {{96{4'h9}}, {32{4'h2}}}) begin errors++; $display("FAIL rskew_beat1: got valid %b data %h", axi_resp.r_valid, axi_resp.r.data); end
            end
            step();
        end
    endtask
`endif

    task automatic test_b_join();
        logic [3:0] exp_ready;
        for (int g = 0; g < 4; g++) grp_resp[g].b.id = 4'(3 + g);
        grp_resp[0].b.resp = RESP_OKAY;
        grp_resp[1].b.resp = RESP_SLVERR;
        grp_resp[2].b.resp = RESP_OKAY;
        grp_resp[3].b.resp = RESP_EXOKAY;
        for (int c = 0; c < 14; c++) begin
            step();
            grp_resp[0].b_valid = (c == 2);
            grp_resp[1].b_valid = (c == 5);
            grp_resp[2].b_valid = (c == 5);
            grp_resp[3].b_valid = (c == 9);
            axi_req.b_ready     = (c == 12);
            if (c <= 2)       exp_ready = 4'b1111;
            else if (c <= 5)  exp_ready = 4'b1110;
            else if (c <= 9)  exp_ready = 4'b1000;
            else if (c <= 12) exp_ready = 4'b0000;
            else              exp_ready = 4'b1111;
            @(negedge clk);
            checks++; if (axi_resp.b_valid !== (c >= 10 && c <= 12)) begin errors++; $display("FAIL b_valid_c%0d: got %b", c, axi_resp.b_valid); end
            checks++; if (grp_b_ready !== exp_ready) begin errors++; $display("FAIL b_grp_ready_c%0d: got %b want %b", c, grp_b_ready, exp_ready); end
            if (c == 10) begin
                checks++; if (axi_resp.b.resp !== RESP_SLVERR || axi_resp.b.id !== 4'd3) begin errors++; $display("FAIL b_fields: got resp %0d id %0d want 2 3", axi_resp.b.resp, axi_resp.b.id); end
            end
        end
        axi_req.b_ready = 1'b0;
    endtask

    task automatic test_b_same_cycle();
        step();
        for (int g = 0; g < 4; g++) begin
            grp_resp[g].b_valid = 1'b1;
            grp_resp[g].b.resp  = RESP_OKAY;
            grp_resp[g].b.id    = 4'(7 + g);
        end
        axi_req.b_ready = 1'b1;
        @(negedge clk);
        checks++; if (axi_resp.b_valid !== 1'b0 || grp_b_ready !== 4'b1111) begin errors++; $display("FAIL bsame_c0: got valid %b ready %b want 0 1111", axi_resp.b_valid, grp_b_ready); end
        step();
        for (int g = 0; g < 4; g++) grp_resp[g].b_valid = 1'b0;
        @(negedge clk);
        checks++; if (axi_resp.b_valid !== 1'b1 || axi_resp.b.resp !== RESP_OKAY || axi_resp.b.id !== 4'd7) begin errors++; $display("FAIL bsame_c1: got valid %b resp %0d id %0d want 1 0 7", axi_resp.b_valid, axi_resp.b.resp, axi_resp.b.id); end
        step();
        @(negedge clk);
        checks++; if (axi_resp.b_valid !== 1'b0 || grp_b_ready !== 4'b1111) begin errors++; $display("FAIL bsame_c2: got valid %b ready %b want 0 1111", axi_resp.b_valid, grp_b_ready); end
        axi_req.b_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        step();
        axi_req.aw_valid = 1'b1;
        for (int g = 0; g < 4; g++) grp_resp[g].aw_ready = (g < 2);
        step();
        for (int g = 0; g < 4; g++) grp_resp[g].aw_ready = 1'b0;
        grp_resp[0].b_valid = 1'b1;
        @(negedge clk);
        checks++; if (grp_aw_valid !== 4'b1100) begin errors++; $display("FAIL rstmid_acc: got %b want 1100", grp_aw_valid); end
        step();
        grp_resp[0].b_valid = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        @(negedge clk);
        checks++; if (grp_aw_valid !== 4'b1111) begin errors++; $display("FAIL rstmid_acc_clear: got %b want 1111", grp_aw_valid); end
        checks++; if (axi_resp.b_valid !== 1'b0 || grp_b_ready !== 4'b1111) begin errors++; $display("FAIL rstmid_b: got valid %b ready %b want 0 1111", axi_resp.b_valid, grp_b_ready); end
        axi_req.aw_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ar_fork();
        test_back_to_back();
        test_w_split();
`ifndef GRP_AXI_SPLIT_RSKEW_EN
        test_r_skew();
        test_resp_merge();
`else
        test_rskew();
`endif
        test_b_join();
        test_b_same_cycle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
